// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade output stage.
package led_pkg;
  localparam int N_LED    = 8;
  localparam int PWM_BITS = 8;
  localparam int LVL_MAX  = (1 << PWM_BITS) - 1;

  typedef logic [PWM_BITS-1:0] lvl_t;
endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating brightness level that ramps toward its target,
// plus the PWM compare that turns the level into a raw drive bit.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS  = led_pkg::PWM_BITS,
  parameter int FADE_STEP = 8
) (
  input  logic                mclk,
  input  logic                rst_n,
  input  logic                target,
  input  logic                fade_tick,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                raw,
  output logic                at_target
);

  localparam logic [PWM_BITS:0]   LVL_MAX_W = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(FADE_STEP);
  localparam logic [PWM_BITS-1:0] LVL_FULL  = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] lvl_reg;
  logic [PWM_BITS-1:0] lvl_next;
  logic [PWM_BITS:0]   up_sum;
  logic [PWM_BITS:0]   dn_diff;

  // One extra bit of headroom lets overflow and borrow be detected and clamped.
  always_comb begin
    up_sum   = {1'b0, lvl_reg} + STEP_W;
    dn_diff  = {1'b0, lvl_reg} - STEP_W;
    lvl_next = lvl_reg;
    if (fade_tick && enable) begin
      if (target) begin
        lvl_next = (up_sum > LVL_MAX_W) ? LVL_FULL : up_sum[PWM_BITS-1:0];
      end else begin
        lvl_next = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_reg <= '0;
    end else begin
      lvl_reg <= lvl_next;
    end
  end

  // Full level forces the drive high so there is no dark cycle at pwm_cnt==max.
  always_comb begin
    raw       = (lvl_reg == LVL_FULL) || (pwm_cnt < lvl_reg);
    at_target = target ? (lvl_reg == LVL_FULL) : (lvl_reg == '0);
  end

endmodule

// File: rtl/led_fade_driver.sv
// LED output stage: captures the sequencer pattern, generates fade ticks and
// the shared PWM ramp, and registers the per-channel drive and busy flag.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int N_LED     = led_pkg::N_LED,
  parameter int PWM_BITS  = led_pkg::PWM_BITS,
  parameter int STEP_DIV  = 4096,
  parameter int FADE_STEP = 8
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] pat_in,
  input  logic             pat_valid,
  input  logic             enable,
  output logic [N_LED-1:0] led,
  output logic             busy
);

  localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);

  logic [N_LED-1:0]    target_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [N_LED-1:0]    led_reg;
  logic                busy_reg;
  logic                fade_tick;
  logic [N_LED-1:0]    raw_vec;
  logic [N_LED-1:0]    at_target_vec;

  assign fade_tick = enable && (tick_cnt_reg == TICK_LAST);

  // Channels see the pre-edge target, so a coincident pat_valid only affects later ticks.
  generate
    for (genvar gi = 0; gi < N_LED; gi++) begin : gen_ch
      led_fade_channel #(
        .PWM_BITS  (PWM_BITS),
        .FADE_STEP (FADE_STEP)
      ) u_ch (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .target    (target_reg[gi]),
        .fade_tick (fade_tick),
        .enable    (enable),
        .pwm_cnt   (pwm_cnt_reg),
        .raw       (raw_vec[gi]),
        .at_target (at_target_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      target_reg   <= '0;
      tick_cnt_reg <= '0;
      pwm_cnt_reg  <= '0;
      led_reg      <= '0;
      busy_reg     <= 1'b0;
    end else if (enable) begin
      if (pat_valid) begin
        target_reg <= pat_in;
      end
      tick_cnt_reg <= (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
      pwm_cnt_reg  <= pwm_cnt_reg + 1'b1;
      led_reg      <= raw_vec;
      busy_reg     <= |(~at_target_vec);
    end else begin
      led_reg <= '0;
    end
  end

  assign led  = led_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed-plus-random bench for led_fade_driver against a cycle model built
// from integer arithmetic on levels, counters and the pattern target.
module tb_led_fade_driver;
  import led_pkg::*;

  localparam int NL  = 8;
  localparam int SD  = 4;
  localparam int FS  = 64;
  localparam int MAX = 255;

  logic          mclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] pat_in = '0;
  logic          pat_valid = 1'b0;
  logic          enable = 1'b0;
  logic [NL-1:0] led;
  logic          busy;

  led_fade_driver #(
    .N_LED     (NL),
    .PWM_BITS  (8),
    .STEP_DIV  (SD),
    .FADE_STEP (FS)
  ) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .pat_in    (pat_in),
    .pat_valid (pat_valid),
    .enable    (enable),
    .led       (led),
    .busy      (busy)
  );

  always #5 mclk = ~mclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int            m_lvl [NL];
  int            m_tick;
  int            m_pwm;
  logic [NL-1:0] m_target;
  logic [NL-1:0] m_led;
  logic          m_busy;

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) m_lvl[i] = 0;
    m_tick = 0; m_pwm = 0; m_target = '0; m_led = '0; m_busy = 1'b0;
  endfunction

  // Apply one rising edge using the inputs and state present just before it.
  function automatic void model_edge(logic en, logic pv, logic [NL-1:0] pat);
    logic          fade;
    logic [NL-1:0] nled;
    logic          nbusy;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fade  = en && (m_tick == SD - 1);
    nled  = '0;
    nbusy = 1'b0;
    for (int i = 0; i < NL; i++) begin
      nled[i] = (m_lvl[i] == MAX) || (m_pwm < m_lvl[i]);
      if (m_target[i] ? (m_lvl[i] != MAX) : (m_lvl[i] != 0)) nbusy = 1'b1;
    end
    m_led  = en ? nled : '0;
    m_busy = en ? nbusy : m_busy;
    if (fade) begin
      for (int i = 0; i < NL; i++)
        m_lvl[i] = m_target[i] ? ((m_lvl[i] + FS > MAX) ? MAX : m_lvl[i] + FS)
                               : ((m_lvl[i] - FS < 0) ? 0 : m_lvl[i] - FS);
    end
    if (en && pv) m_target = pat;
    if (en) begin
      m_tick = (m_tick + 1) % SD;
      m_pwm  = (m_pwm + 1) % (MAX + 1);
    end
  endfunction

  task automatic check(string tag, logic [NL-1:0] exp_led, logic exp_busy);
    vectors++;
    assert (led === exp_led) else begin
      miscompares++;
      $error("FAIL %s led observed=%h expected=%h t=%0t", tag, led, exp_led, $time);
    end
    vectors++;
    assert (busy === exp_busy) else begin
      miscompares++;
      $error("FAIL %s busy observed=%b expected=%b t=%0t", tag, busy, exp_busy, $time);
    end
  endtask

  // One clock: inputs already driven, model the edge, compare on the falling edge.
  task automatic cycle(string tag);
    @(posedge mclk);
    model_edge(enable, pat_valid, pat_in);
    @(negedge mclk);
    check(tag, m_led, m_busy);
  endtask

  task automatic run(string tag, int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  task automatic load(logic [NL-1:0] p, string tag);
    pat_in = p; pat_valid = 1'b1;
    cycle(tag);
    pat_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge mclk);
    run("reset_hold", 5);
    check("reset_state", '0, 1'b0);
    rst_n = 1'b1; enable = 1'b1;

    // Idle: no pattern ever loaded
    run("idle", 2000);

    // Fade-up on LED 0 through the whole ramp to saturation
    load(8'h01, "fadeup_load");
    run("fadeup", 40);

    // Reverse once lvl[0] reaches 128 on the way up
    load(8'h00, "rev_clear");
    run("rev_settle", 30);
    load(8'h01, "rev_up");
    while (m_lvl[0] != 128) cycle("rev_up_wait");
    load(8'h00, "rev_down");
    run("rev_fall", 20);
    check("rev_dark", 8'h00, 1'b0);

    // pat_valid on the fade-tick cycle must not redirect that tick
    load(8'hF0, "sim_prep");
    run("sim_prep_run", 5);
    while (m_tick != SD - 1) cycle("sim_align");
    load(8'h0F, "sim_coincide");
    run("sim_after", 40);

    // Enable gating mid-fade
    load(8'hAA, "gate_load");
    run("gate_pre", 6);
    enable = 1'b0;
    run("gate_off", 50);
    check("gate_blank", 8'h00, m_busy);
    enable = 1'b1;
    run("gate_resume", 40);

    // Randomized patterns, strobes and enable drops
    for (int k = 0; k < 1500; k++) begin
      pat_in    = NL'($urandom);
      pat_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      cycle("random");
    end
    pat_valid = 1'b0; enable = 1'b1;

    // Asynchronous reset between edges while mid-fade
    load(8'hFF, "areset_load");
    run("areset_pre", 6);
    #2 rst_n = 1'b0;
    #1 check("areset_immediate", 8'h00, 1'b0);
    model_reset();
    @(negedge mclk);
    run("areset_hold", 3);
    rst_n = 1'b1;
    run("areset_dark", 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout bench did not complete observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream output stage of the LED pattern sequencer. It consumes the 8-bit pattern the sequencer produces and drives the physical LED pins.
- Each LED bit has its own brightness level that ramps, with saturation, toward full-on or full-off at a programmable rate.
- The ramp turns hard pattern steps into visible fades. The LED pins are driven by a free-running PWM comparator.
- Runs directly on mclk. The sequencer's pattern-change strobe marks when a new pattern is available.

Parameters:
- N_LED, 8, number of LED channels (pattern and output width).
- PWM_BITS, 8, width of the brightness level and PWM counter; LVL_MAX = 2^PWM_BITS-1.
- STEP_DIV, 4096, mclk cycles between fade ticks (legal range >= 2).
- FADE_STEP, 8, brightness change applied per fade tick (legal range 1..LVL_MAX).

Ports:
- mclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pat_in  in  N_LED  target pattern; 1 = LED on.
- pat_valid  in  1  single-cycle strobe; captures pat_in.
- enable  in  1  1 = run; 0 = blank outputs and freeze all counters and levels.
- led  out  N_LED  PWM-modulated LED drive, registered.
- busy  out  1  1 while any channel level is not at its target endpoint, registered.

Behaviour:
- Reset: target=0, all lvl[i]=0, pwm_cnt=0, tick_cnt=0, led=0, busy=0.
- Target capture: pat_valid=1 at edge t loads target<=pat_in, visible from t+1. pat_valid is ignored while enable=0.
- Fade tick generator:
  - tick_cnt counts 0..STEP_DIV-1 and wraps.
  - fade_tick is asserted for one cycle when tick_cnt==STEP_DIV-1 and enable=1.
- Level update on fade_tick, per channel:
  - target[i]=1: lvl<=min(lvl+FADE_STEP, LVL_MAX).
  - target[i]=0: lvl<=max(lvl-FADE_STEP, 0).
  - Arithmetic is done at PWM_BITS+1 width, then saturated. Wrap-around is never allowed.
- Same-cycle pat_valid and fade_tick: that tick uses the old target. The new target takes effect from the next tick.
- Target reversal mid-fade: the level reverses direction from its current value. There is no jump and no restart from an endpoint.
- PWM:
  - pwm_cnt is free-running 0..LVL_MAX, wrapping LVL_MAX->0, and advances only when enable=1.
  - Raw output raw[i] = (lvl[i]==LVL_MAX) ? 1 : (pwm_cnt < lvl[i]).
  - lvl=0 gives constant 0; lvl=LVL_MAX gives constant 1 (no single-cycle glitch).
  - led <= raw, so led lags the compare by 1 cycle.
- enable=0:
  - From the next edge, led=0 and busy holds its last value.
  - tick_cnt, pwm_cnt and lvl hold.
  - On re-enable, counting resumes from the held values.
- busy <= OR over i of ((target[i] && lvl[i]!=LVL_MAX) || (!target[i] && lvl[i]!=0)).
- Reset asserted mid-fade: all state clears immediately (asynchronous). After release, all LEDs stay dark until a new pat_valid.
- Full-ramp latency for 0->LVL_MAX: ceil(LVL_MAX/FADE_STEP) fade ticks.

Decomposition:
- Shared package led_pkg:
  - Constants N_LED, PWM_BITS, LVL_MAX.
  - Typedef lvl_t (PWM_BITS-bit level).
- Sub-module led_fade_channel, instantiated N_LED times:
  - Inputs: target bit, fade_tick, pwm_cnt, enable.
  - Outputs: raw drive bit, at_target flag.
  - Holds that channel's saturating level register.
- Top level owns the target register, tick_cnt, pwm_cnt, the led/busy output registers and the busy OR-reduction.

Test Plan (sim params STEP_DIV=4, FADE_STEP=64, PWM_BITS=8):
- Reset/idle: rst_n low then high, enable=1, no pat_valid -> led=0x00 and busy=0 for 2000 cycles.
- Fade-up: pat_in=0x01 with pat_valid pulse -> busy=1 from the next cycle. lvl[0] steps 64,128,192,255 on successive ticks. led[0] duty per 256-cycle PWM period = 64/256 at lvl=64, then constant 1 at 255. busy=0 after the 4th tick.
- Reversal: from lvl[0]=128 (target 1), pat_in=0x00 -> next ticks give 64 then 0 (no jump). led[0] becomes constant 0 and busy drops.
- Simultaneous: pat_valid coincides with fade_tick -> that tick still ramps toward the old target. The direction change appears on the following tick.
- Enable gating: drop enable mid-fade for 50 cycles -> led=0x00 and lvl/pwm_cnt/tick_cnt frozen. After re-enable, the ramp continues from the frozen values.
- Async reset mid-fade: pull rst_n low between clock edges -> led, busy and all levels read 0 before the next mclk edge.
